regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/wb_hold_buf.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default data
// width and the requester identifiers used by the arbitration state.
package regfile_wb_arbiter_pkg;

  localparam int WB_SIZE = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback hold buffer. It captures a request when empty and
// holds it unchanged until it is granted to the register file or discarded.
module wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int SIZE   = WB_SIZE,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid,
  input  logic [NREG_W-1:0] wreg,
  input  logic [SIZE-1:0]   wdata,
  input  logic              grant,
  output logic              ready,
  output logic              full,
  output logic [NREG_W-1:0] held_reg,
  output logic [SIZE-1:0]   held_data
);

  // A full buffer never refills in the cycle it drains, so ready is plain !full.
  assign ready = !full;

  // Fill on accept, drain on grant; flush discards regardless of either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      held_reg  <= '0;
      held_data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (valid && !full) begin
      full      <= 1'b1;
      held_reg  <= wreg;
      held_data <= wdata;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and memory writebacks onto a single register-file write
// port. Each requester parks one result in a hold buffer; one buffer is
// drained per cycle into registered write/writeReg/data outputs.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int SIZE   = WB_SIZE,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [NREG_W-1:0] alu_reg,
  input  logic [SIZE-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [NREG_W-1:0] mem_reg,
  input  logic [SIZE-1:0]   mem_data,
  output logic              mem_ready,
  output logic              write,
  output logic [NREG_W-1:0] writeReg,
  output logic [SIZE-1:0]   data,
  output logic              busy
);

  logic              alu_full, mem_full;
  logic [NREG_W-1:0] alu_held_reg, mem_held_reg;
  logic [SIZE-1:0]   alu_held_data, mem_held_data;
  logic              alu_grant, mem_grant;
  logic              alu_acc, mem_acc;
  req_id_t           last_grant, age, sel;

  wb_hold_buf #(.SIZE(SIZE), .NREG_W(NREG_W)) u_alu_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .valid(alu_valid), .wreg(alu_reg), .wdata(alu_data),
    .grant(alu_grant), .ready(alu_ready), .full(alu_full),
    .held_reg(alu_held_reg), .held_data(alu_held_data)
  );

  wb_hold_buf #(.SIZE(SIZE), .NREG_W(NREG_W)) u_mem_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .valid(mem_valid), .wreg(mem_reg), .wdata(mem_data),
    .grant(mem_grant), .ready(mem_ready), .full(mem_full),
    .held_reg(mem_held_reg), .held_data(mem_held_data)
  );

  assign busy    = alu_full | mem_full;
  assign alu_acc = alu_valid && !alu_full && !flush;
  assign mem_acc = mem_valid && !mem_full && !flush;

  // Grant select: same destination keeps program order (older first),
  // otherwise alternate against the last winner; a lone full buffer wins.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    sel       = REQ_ALU;
    if (!flush) begin
      if (alu_full && mem_full) begin
        if (alu_held_reg == mem_held_reg) sel = age;
        else sel = (last_grant == REQ_ALU) ? REQ_MEM : REQ_ALU;
        alu_grant = (sel == REQ_ALU);
        mem_grant = (sel == REQ_MEM);
      end else begin
        alu_grant = alu_full;
        mem_grant = mem_full;
      end
    end
  end

  // Register-file write port; write index and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write    <= 1'b0;
      writeReg <= '0;
      data     <= '0;
    end else if (alu_grant) begin
      write    <= 1'b1;
      writeReg <= alu_held_reg;
      data     <= alu_held_data;
    end else if (mem_grant) begin
      write    <= 1'b1;
      writeReg <= mem_held_reg;
      data     <= mem_held_data;
    end else begin
      write <= 1'b0;
    end
  end

  // Fairness and ordering state. age names the older buffer: a new ALU
  // fill makes MEM the older one (also when both fill together), a lone
  // MEM fill makes ALU the older one. age only matters while both are full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_MEM;
      age        <= REQ_ALU;
    end else begin
      if (alu_grant) last_grant <= REQ_ALU;
      else if (mem_grant) last_grant <= REQ_MEM;
      if (alu_acc) age <= REQ_MEM;
      else if (mem_acc) age <= REQ_ALU;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int SIZE   = WB_SIZE;
  localparam int NREG_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              alu_valid, mem_valid;
  logic [NREG_W-1:0] alu_reg, mem_reg;
  logic [SIZE-1:0]   alu_data, mem_data;
  logic              alu_ready, mem_ready;
  logic              write;
  logic [NREG_W-1:0] writeReg;
  logic [SIZE-1:0]   data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.SIZE(SIZE), .NREG_W(NREG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .write(write), .writeReg(writeReg), .data(data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    // Reset state
    chk("rst_write", write, 0);
    chk("rst_wreg", writeReg, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    rst = 1'b0;

    // Single ALU writeback, two edges after accept
    alu_valid = 1; alu_reg = 10; alu_data = 12345;
    step();
    chk("s1_busy", busy, 1);
    chk("s1_alu_ready", alu_ready, 0);
    chk("s1_write0", write, 0);
    alu_valid = 0;
    step();
    chk("s1_write", write, 1);
    chk("s1_wreg", writeReg, 10);
    chk("s1_data", data, 12345);
    chk("s1_busy_after", busy, 0);
    step();
    chk("s1_write_drop", write, 0);
    chk("s1_wreg_hold", writeReg, 10);
    chk("s1_data_hold", data, 12345);

    // Simultaneous, different regs: ALU first after reset
    do_reset();
    alu_valid = 1; alu_reg = 10; alu_data = 12345;
    mem_valid = 1; mem_reg = 15; mem_data = 54321;
    step();
    chk("s2_busy", busy, 1);
    chk("s2_alu_ready", alu_ready, 0);
    chk("s2_mem_ready", mem_ready, 0);
    alu_valid = 0; mem_valid = 0;
    step();
    chk("s2_w1", write, 1);
    chk("s2_w1_reg", writeReg, 10);
    chk("s2_w1_data", data, 12345);
    chk("s2_w1_mem_ready", mem_ready, 0);
    step();
    chk("s2_w2", write, 1);
    chk("s2_w2_reg", writeReg, 15);
    chk("s2_w2_data", data, 54321);
    chk("s2_w2_busy", busy, 0);
    step();
    chk("s2_idle", write, 0);

    // Simultaneous, same reg: MEM (older) first, ALU last value sticks
    do_reset();
    alu_valid = 1; alu_reg = 15; alu_data = 2332;
    mem_valid = 1; mem_reg = 15; mem_data = 54321;
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    chk("s3_w1", write, 1);
    chk("s3_w1_reg", writeReg, 15);
    chk("s3_w1_data", data, 54321);
    step();
    chk("s3_w2", write, 1);
    chk("s3_w2_data", data, 2332);
    step();
    chk("s3_idle", write, 0);
    chk("s3_final", data, 2332);

    // Both valid every cycle for 20 cycles, distinct regs
    do_reset();
    for (int j = 0; j < 20; j++) begin
      alu_valid = 1; alu_reg = NREG_W'(1 + j % 8);  alu_data = SIZE'('hA00 + j);
      mem_valid = 1; mem_reg = NREG_W'(16 + j % 8); mem_data = SIZE'('hB00 + j);
      step();
      chk("s4_alu_ready", alu_ready, (j % 2));
      chk("s4_mem_ready", mem_ready, (j >= 2 && j % 2 == 0));
      if (j == 0) begin
        chk("s4_write0", write, 0);
      end else if (j % 2 == 1) begin
        chk("s4_alu_w", write, 1);
        chk("s4_alu_reg", writeReg, 1 + (j - 1) % 8);
        chk("s4_alu_data", data, 'hA00 + j - 1);
      end else begin
        chk("s4_mem_w", write, 1);
        chk("s4_mem_reg", writeReg, (j == 2) ? 16 : 16 + (j - 1) % 8);
        chk("s4_mem_data", data, (j == 2) ? 'hB00 : 'hB00 + j - 1);
      end
    end
    alu_valid = 0; mem_valid = 0;
    step();
    chk("s4_tail_w", write, 1);
    chk("s4_tail_reg", writeReg, 19);
    chk("s4_tail_data", data, 'hB13);
    step();
    chk("s4_end_w", write, 0);
    chk("s4_end_busy", busy, 0);

    // Flush with both buffers full
    do_reset();
    alu_valid = 1; alu_reg = 1; alu_data = 11;
    mem_valid = 1; mem_reg = 2; mem_data = 22;
    step();
    alu_valid = 0; mem_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("s5_write", write, 0);
    chk("s5_busy", busy, 0);
    chk("s5_alu_ready", alu_ready, 1);
    chk("s5_mem_ready", mem_ready, 1);
    step();
    chk("s5_write_n1", write, 0);
    step();
    chk("s5_write_n2", write, 0);
    flush = 1; alu_valid = 1; alu_reg = 5; alu_data = 55;
    step();
    flush = 0; alu_valid = 0;
    chk("s5_flush_acc", alu_ready, 1);
    chk("s5_flush_busy", busy, 0);
    step();
    chk("s5_flush_w", write, 0);

    // Asynchronous reset mid-transaction
    do_reset();
    alu_valid = 1; alu_reg = 3; alu_data = 7;
    mem_valid = 1; mem_reg = 4; mem_data = 8;
    step();
    alu_valid = 0; mem_valid = 0;
    step();
    chk("s6_pre_w", write, 1);
    chk("s6_pre_reg", writeReg, 3);
    #2 rst = 1;
    #1;
    chk("s6_rst_w", write, 0);
    chk("s6_rst_reg", writeReg, 0);
    chk("s6_rst_data", data, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_alu_ready", alu_ready, 1);
    chk("s6_rst_mem_ready", mem_ready, 1);
    #1 rst = 0;
    step();
    chk("s6_post_w1", write, 0);
    chk("s6_post_busy", busy, 0);
    step();
    chk("s6_post_w2", write, 0);
    alu_valid = 1; alu_reg = 9; alu_data = 99;
    step();
    alu_valid = 0;
    chk("s6_new_busy", busy, 1);
    step();
    chk("s6_new_w", write, 1);
    chk("s6_new_reg", writeReg, 9);
    chk("s6_new_data", data, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
